// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes five static 7-segment patterns onto one
// shared segment bus with per-digit anode enables. The patterns are captured
// once per frame so a mid-scan change cannot tear across digits. Each digit
// slot starts with a blanking interval to suppress ghosting.
//
// Optional feature, enabled by defining SEG_SCAN_DIM_EN: adds a 3-bit
// brightness input. It shortens the lit part of every SHOW interval to
// ((brightness+1)*L)/8 cycles, where L is the SHOW length. It never goes
// below one lit cycle.
//
// Every output is a flop loaded from the next-state decode. The value seen
// during a cycle therefore belongs to that cycle's (idx, cnt) position.

module seg_scan_mux #(
    parameter int         NUM_DIGITS    = 5,
    parameter int         REFRESH_DIV   = 50000,
    parameter int         BLANK_CYCLES  = 500,
    parameter int         AN_ACTIVE_LOW = 1,
    parameter logic [6:0] SEG_OFF       = 7'h7F
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0]            brightness,
`endif
    input  logic [6:0]            disp0,
    input  logic [6:0]            disp1,
    input  logic [6:0]            disp2,
    input  logic [6:0]            disp3,
    input  logic [6:0]            disp4,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic                  AN_ON     = (AN_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_NONE   = {NUM_DIGITS{~AN_ON}};

    // Reject configurations the counters and the anode vector cannot represent.
    generate
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
            $error("seg_scan_mux: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_mux: NUM_DIGITS must be in 2..8");
        end
    endgenerate

    // IDLE: scanning stopped (reset or en=0). The other three phases split a
    // digit slot into its blank lead-in, its lit window, and its dimmed tail.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_BLANK,
        PH_SHOW,
        PH_DARK
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      snap_q [NUM_DIGITS];
    logic [6:0]      snap_d [NUM_DIGITS];
    logic [6:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic            frame_tick_q, frame_tick_d;
    logic            lit_d;

`ifdef SEG_SCAN_DIM_EN
    localparam logic [31:0] LIT_SPAN = 32'(REFRESH_DIV - BLANK_CYCLES);

    logic [2:0]  bright_q, bright_d;
    logic [31:0] lit_len;
    logic [31:0] show_off;
`endif

    // Slot position: (0,0) is held while stopped, and also on the first
    // enabled cycle after a stop. From there cnt and idx advance and wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx_d = '0;
        cnt_d = '0;
        if (en && phase_q != PH_IDLE) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
                idx_d = idx_q;
            end
        end
    end

    // Frame capture: the cycle that pulsed frame_tick samples all patterns
    // (and brightness) at its end. The snapshot holds between captures.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            snap_d[i] = snap_q[i];
        end
`ifdef SEG_SCAN_DIM_EN
        bright_d = bright_q;
`endif
        if (frame_tick_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                case (i)
                    0:       snap_d[i] = disp0;
                    1:       snap_d[i] = disp1;
                    2:       snap_d[i] = disp2;
                    3:       snap_d[i] = disp3;
                    4:       snap_d[i] = disp4;
                    default: snap_d[i] = SEG_OFF;
                endcase
            end
`ifdef SEG_SCAN_DIM_EN
            bright_d = brightness;
`endif
        end
    end

`ifdef SEG_SCAN_DIM_EN
    // Dimming window: the lit part of SHOW scales with brightness. It is kept
    // at least one cycle, so the lowest setting is dim rather than dark.
    always_comb begin
        lit_len = ((32'(bright_d) + 32'd1) * LIT_SPAN) / 32'd8;
        if (lit_len == 32'd0) begin
            lit_len = 32'd1;
        end
        show_off = 32'(cnt_d) - 32'(BLANK_CYCLES);
        lit_d    = (show_off < lit_len);
    end
`else
    assign lit_d = 1'b1;
`endif

    // Next-phase and output decode, taken from the next slot position so the
    // registered outputs line up with the cycle they describe.
    always_comb begin
        phase_d = PH_IDLE;
        if (en) begin
            if (cnt_d < CNT_BLANK) begin
                phase_d = PH_BLANK;
            end else if (lit_d) begin
                phase_d = PH_SHOW;
            end else begin
                phase_d = PH_DARK;
            end
        end

        frame_tick_d = (phase_d != PH_IDLE) && (idx_d == '0) && (cnt_d == '0);

        seg_d = SEG_OFF;
        an_d  = AN_NONE;
        if (phase_d == PH_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IW'(i)) begin
                    an_d[i] = AN_ON;
                    seg_d   = snap_d[i];
                end
            end
        end
    end

    // Scan FSM and output registers. A synchronous reset takes priority over en.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            phase_q      <= PH_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            // NOTE: the snapshot is a small bank of flops, not a RAM, so resetting every entry is legal and gives the defined all-off picture.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= SEG_OFF;
            end
            seg_q        <= SEG_OFF;
            an_q         <= AN_NONE;
            frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            bright_q     <= 3'd7;
`endif
        end else begin
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= snap_d[i];
            end
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
`ifdef SEG_SCAN_DIM_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: drives seg_scan_mux with NUM_DIGITS=5, REFRESH_DIV=8,
// BLANK_CYCLES=2 and active-low anodes. It compares every output on every
// cycle against a frame-position model. Literal spot checks pin that model
// to hand-derived values.

module tb_seg_scan_mux;

    localparam int ND    = 5;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [6:0]       din [ND];
    logic [6:0]       seg;
    logic [ND-1:0]    an;
    logic             frame_tick;
`ifdef SEG_SCAN_DIM_EN
    logic [2:0]       brightness = 3'd7;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .AN_ACTIVE_LOW(1),
        .SEG_OFF      (7'h7F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
`ifdef SEG_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .disp0      (din[0]),
        .disp1      (din[1]),
        .disp2      (din[2]),
        .disp3      (din[3]),
        .disp4      (din[4]),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: track the position within the frame (0..FRAME-1) and
    // derive the slot and offset by division. Patterns are latched at the end
    // of every cycle whose expected frame_tick was 1.
    bit         m_valid = 1'b0;
    bit         m_active = 1'b0;
    bit         m_prev_tick = 1'b0;
    int         m_pos = 0;
    logic [6:0] m_snap [ND];
    logic [6:0] e_seg;
    logic [ND-1:0] e_an;
    logic       e_tick;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_pos    = 0;
            for (int i = 0; i < ND; i++) m_snap[i] = 7'h7F;
            e_tick = 1'b0;
            e_an   = '1;
            e_seg  = 7'h7F;
        end else begin
            if (m_prev_tick) begin
                for (int i = 0; i < ND; i++) m_snap[i] = din[i];
            end
            if (!en) begin
                m_active = 1'b0;
                m_pos    = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            e_tick = m_active && (m_pos == 0);
            e_an   = '1;
            e_seg  = 7'h7F;
            if (m_active && (m_pos % RD) >= BC) begin
                e_an[m_pos / RD] = 1'b0;
                e_seg            = m_snap[m_pos / RD];
            end
        end
        m_prev_tick = e_tick;
        #1;
        if (m_valid) begin
            check("model_seg",  32'(seg),        32'(e_seg));
            check("model_an",   32'(an),         32'(e_an));
            check("model_tick", 32'(frame_tick), 32'(e_tick));
        end
    end

    // Advance to the middle of cycle n, counted from the first enabled cycle.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Hold reset for three cycles (with en=1, so reset is seen to win),
    // check the reset outputs, then release so the next edge starts cycle 0.
    task automatic start_run();
        reset = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an",   32'(an),         32'h1F);
        check("rst_seg",  32'(seg),        32'h7F);
        check("rst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        cyc   = -1;
    endtask

    task automatic expect_out(input string name, input logic [4:0] a, input logic [6:0] s);
        check({name, "_an"},  32'(an),  32'(a));
        check({name, "_seg"}, 32'(seg), 32'(s));
    endtask

    initial begin
        din[0] = 7'h01;
        din[1] = 7'h02;
        din[2] = 7'h04;
        din[3] = 7'h08;
        din[4] = 7'h10;

        // Basic scan, frame ticks, and a mid-frame pattern change.
        start_run();
        goto(0);  check("c0_tick", 32'(frame_tick), 32'h1);
                  expect_out("c0", 5'h1F, 7'h7F);
        goto(1);  check("c1_tick", 32'(frame_tick), 32'h0);
                  expect_out("c1", 5'h1F, 7'h7F);
        goto(3);  expect_out("c3", 5'h1E, 7'h01);
        goto(5);  din[2] = 7'h40;
        goto(9);  expect_out("c9", 5'h1F, 7'h7F);
        goto(12); expect_out("c12", 5'h1D, 7'h02);
        goto(20); expect_out("c20", 5'h1B, 7'h04);
        goto(37); expect_out("c37", 5'h0F, 7'h10);
        goto(39); check("c39_tick", 32'(frame_tick), 32'h0);
        goto(40); check("c40_tick", 32'(frame_tick), 32'h1);
        goto(60); expect_out("c60", 5'h1B, 7'h40);
        goto(80); check("c80_tick", 32'(frame_tick), 32'h1);

        // Enable dropped during slot 3 SHOW, then restored.
        start_run();
        goto(27); en = 1'b0;
        goto(28); expect_out("en28", 5'h1F, 7'h7F);
                  check("en28_tick", 32'(frame_tick), 32'h0);
        goto(30); check("en30_tick", 32'(frame_tick), 32'h0);
        goto(32); en = 1'b1;
        goto(33); check("en33_tick", 32'(frame_tick), 32'h1);
        goto(34); expect_out("en34", 5'h1F, 7'h7F);
        goto(35); expect_out("en35", 5'h1E, 7'h01);
        goto(40); expect_out("en40", 5'h1E, 7'h01);
        goto(41); expect_out("en41", 5'h1F, 7'h7F);

        // Reset pulsed during slot 1 SHOW.
        start_run();
        goto(12); expect_out("r12", 5'h1D, 7'h02);
        goto(13); reset = 1'b1;
        goto(14); expect_out("r14", 5'h1F, 7'h7F);
                  check("r14_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        cyc   = -1;
        goto(0);  check("r0_tick", 32'(frame_tick), 32'h1);
        goto(3);  expect_out("r3", 5'h1E, 7'h01);

        // Random pattern churn, occasional enable drops and resets.
        start_run();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) din[$urandom_range(0, ND - 1)] = 7'($urandom);
            en    = ($urandom_range(0, 199) != 0);
            reset = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
